// File: rtl/dpc_linebuf_ctrl.sv
// Sequencer for a 3x3 line-buffer pixel pipeline: frame sync, priming, window tagging and end-of-frame flush.
// Defining DPC_LBCTRL_STATS_EN adds the frame_cnt/err_cnt statistics outputs.
module dpc_linebuf_ctrl #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 512
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        s_valid,
    input  logic        s_sof,
    input  logic        s_eol,
    output logic        s_ready,
    output logic        lb_in_valid,
    output logic        lb_reset,
    output logic        pad_sel,
    output logic        win_valid,
    output logic [10:0] win_col,
    output logic [10:0] win_row,
    output logic [3:0]  win_edge,
    output logic        frame_done,
    output logic        err_eol,
    input  logic        err_clr
`ifdef DPC_LBCTRL_STATS_EN
    ,
    output logic [15:0] frame_cnt,
    output logic [7:0]  err_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, PRIME, STREAM, FLUSH} state_t;

    localparam logic [10:0] COL_LAST   = 11'(IMG_W - 1);
    localparam logic [10:0] ROW_LAST   = 11'(IMG_H - 1);
    localparam logic [10:0] FLUSH_LAST = 11'(IMG_W);

    state_t      state_q, state_d;
    logic [10:0] inCol_q, inCol_d, inRow_q, inRow_d;
    logic [10:0] cenCol_q, cenCol_d, cenRow_q, cenRow_d;
    logic [10:0] flushCnt_q, flushCnt_d;
    logic        ready_q, padSel_q, winValid_q, frameDone_q, lbReset_q, errEol_q;
    logic [10:0] winCol_q, winRow_q;
    logic [3:0]  winEdge_q;
    logic        accept, eolBad, inFrame, sofEvt, errEvt, goodBeat, winFire, doneEvt;

    // Raster step shared by the input position and the window centre: {row, col}.
    function automatic logic [21:0] rasterStep(input logic [10:0] col, input logic [10:0] row);
        if (col == COL_LAST) rasterStep = {row + 11'd1, 11'd0};
        else                 rasterStep = {row, col + 11'd1};
    endfunction

    always_comb begin
        accept      = s_valid & ready_q;
        eolBad      = s_eol != (inCol_q == COL_LAST);
        inFrame     = (state_q == PRIME) || (state_q == STREAM);
        sofEvt      = inFrame & accept & s_sof;
        errEvt      = inFrame & accept & ~s_sof & eolBad;
        goodBeat    = inFrame & accept & ~s_sof & ~eolBad;
        lb_in_valid = ((state_q == IDLE) & accept & s_sof) | sofEvt | goodBeat | (state_q == FLUSH);
        winFire     = ((state_q == STREAM) & goodBeat) | (state_q == FLUSH);

        state_d    = state_q;
        inCol_d    = inCol_q;
        inRow_d    = inRow_q;
        flushCnt_d = flushCnt_q;
        cenCol_d   = cenCol_q;
        cenRow_d   = cenRow_q;
        doneEvt    = 1'b0;

        if (winFire) {cenRow_d, cenCol_d} = rasterStep(cenCol_q, cenRow_q);

        case (state_q)
            IDLE: begin
                if (accept && s_sof) begin
                    state_d = PRIME;
                    inCol_d = 11'd1;
                    inRow_d = 11'd0;
                end
            end
            PRIME, STREAM: begin
                // A fresh s_sof restarts the frame; an s_eol mismatch abandons it.
                if (sofEvt) begin
                    state_d = PRIME;
                    inCol_d = 11'd1;
                    inRow_d = 11'd0;
                end else if (errEvt) begin
                    state_d = IDLE;
                    inCol_d = 11'd0;
                    inRow_d = 11'd0;
                end else if (goodBeat) begin
                    {inRow_d, inCol_d} = rasterStep(inCol_q, inRow_q);
                    if (state_q == PRIME && inRow_q == 11'd1 && inCol_q == 11'd0) begin
                        state_d  = STREAM;
                        cenCol_d = 11'd0;
                        cenRow_d = 11'd0;
                    end
                    if (inRow_q == ROW_LAST && inCol_q == COL_LAST) begin
                        state_d    = FLUSH;
                        flushCnt_d = 11'd0;
                    end
                end
            end
            FLUSH: begin
                flushCnt_d = flushCnt_q + 11'd1;
                if (flushCnt_q == FLUSH_LAST) begin
                    state_d = IDLE;
                    inCol_d = 11'd0;
                    inRow_d = 11'd0;
                    doneEvt = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            inCol_q     <= 11'd0;
            inRow_q     <= 11'd0;
            cenCol_q    <= 11'd0;
            cenRow_q    <= 11'd0;
            flushCnt_q  <= 11'd0;
            ready_q     <= 1'b0;
            padSel_q    <= 1'b0;
            winValid_q  <= 1'b0;
            winCol_q    <= 11'd0;
            winRow_q    <= 11'd0;
            winEdge_q   <= 4'd0;
            frameDone_q <= 1'b0;
            lbReset_q   <= 1'b1;
            errEol_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            inCol_q     <= inCol_d;
            inRow_q     <= inRow_d;
            cenCol_q    <= cenCol_d;
            cenRow_q    <= cenRow_d;
            flushCnt_q  <= flushCnt_d;
            ready_q     <= (state_d != FLUSH);
            padSel_q    <= (state_d == FLUSH);
            winValid_q  <= winFire;
            winCol_q    <= winFire ? cenCol_q : 11'd0;
            winRow_q    <= winFire ? cenRow_q : 11'd0;
            winEdge_q   <= winFire ? {cenRow_q == 11'd0, cenRow_q == ROW_LAST,
                                      cenCol_q == 11'd0, cenCol_q == COL_LAST} : 4'd0;
            frameDone_q <= doneEvt;
            lbReset_q   <= sofEvt | errEvt;
            errEol_q    <= errEvt ? 1'b1 : (err_clr ? 1'b0 : errEol_q);
        end
    end

`ifdef DPC_LBCTRL_STATS_EN
    logic [15:0] frameCnt_q;
    logic [7:0]  errCnt_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            frameCnt_q <= 16'd0;
            errCnt_q   <= 8'd0;
        end else begin
            if (doneEvt) frameCnt_q <= frameCnt_q + 16'd1;
            if (errEvt && errCnt_q != 8'hFF) errCnt_q <= errCnt_q + 8'd1;
        end
    end

    assign frame_cnt = frameCnt_q;
    assign err_cnt   = errCnt_q;
`endif

    assign s_ready    = ready_q;
    assign pad_sel    = padSel_q;
    assign win_valid  = winValid_q;
    assign win_col    = winCol_q;
    assign win_row    = winRow_q;
    assign win_edge   = winEdge_q;
    assign frame_done = frameDone_q;
    assign lb_reset   = lbReset_q;
    assign err_eol    = errEol_q;

endmodule

// File: tb/tb_dpc_linebuf_ctrl.sv
// Directed bench for dpc_linebuf_ctrl at IMG_W=4, IMG_H=3 with a window scoreboard.
// Statistics checks are compiled in when DPC_LBCTRL_STATS_EN is defined.
module tb_dpc_linebuf_ctrl;

    localparam int W = 4;
    localparam int H = 3;

    logic        clk = 1'b0;
    logic        reset_n, s_valid, s_sof, s_eol, err_clr;
    logic        s_ready, lb_in_valid, lb_reset, pad_sel, win_valid, frame_done, err_eol;
    logic [10:0] win_col, win_row;
    logic [3:0]  win_edge;
`ifdef DPC_LBCTRL_STATS_EN
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;
`endif

    typedef struct packed {
        logic [10:0] row;
        logic [10:0] col;
        logic [3:0]  edg;
        logic        done;
    } winExp_t;

    winExp_t sbq[$];
    int      checks   = 0;
    int      failures = 0;

    dpc_linebuf_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .s_valid    (s_valid),
        .s_sof      (s_sof),
        .s_eol      (s_eol),
        .s_ready    (s_ready),
        .lb_in_valid(lb_in_valid),
        .lb_reset   (lb_reset),
        .pad_sel    (pad_sel),
        .win_valid  (win_valid),
        .win_col    (win_col),
        .win_row    (win_row),
        .win_edge   (win_edge),
        .frame_done (frame_done),
        .err_eol    (err_eol),
        .err_clr    (err_clr)
`ifdef DPC_LBCTRL_STATS_EN
        ,
        .frame_cnt  (frame_cnt),
        .err_cnt    (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pushWindow(input int idx);
        winExp_t e;
        e.row  = 11'(idx / W);
        e.col  = 11'(idx % W);
        e.edg  = {idx / W == 0, idx / W == H - 1, idx % W == 0, idx % W == W - 1};
        e.done = (idx == W * H - 1);
        sbq.push_back(e);
    endtask

    // Every window the DUT emits must match the head of the scoreboard; quiet cycles keep edge/done low.
    always @(negedge clk) begin
        if (win_valid === 1'b1) begin
            checkOutput("win_expected", sbq.size() != 0, 1);
            if (sbq.size() != 0) begin
                winExp_t e;
                e = sbq.pop_front();
                checkOutput("win_row", win_row, e.row);
                checkOutput("win_col", win_col, e.col);
                checkOutput("win_edge", win_edge, e.edg);
                checkOutput("frame_done_win", frame_done, e.done);
            end
        end else begin
            checkOutput("idle_edge_done", {frame_done, win_edge}, 0);
        end
    end

    task automatic applyStimulus(input bit sof, input bit eol, input int stallPct,
                                 output logic lbv, output logic firstWin);
        int  tries = 0;
        bit  done  = 0;
        bit  v;
        lbv = 1'b0;
        firstWin = 1'bx;
        while (!done && tries < 64) begin
            v = !(stallPct > 0 && $urandom_range(0, 99) < stallPct);
            s_valid = v;
            s_sof   = sof;
            s_eol   = eol;
            @(negedge clk);
            if (tries == 0) firstWin = win_valid;
            checkOutput("s_ready_in_frame", s_ready, 1);
            if (!v) checkOutput("lb_in_valid_stall", lb_in_valid, 0);
            if (v && s_ready === 1'b1) begin
                done = 1;
                lbv  = lb_in_valid;
            end
            @(posedge clk); #1;
            tries++;
        end
        checkOutput("beat_accepted", done, 1);
        s_valid = 1'b0;
        s_sof   = 1'b0;
        s_eol   = 1'b0;
    endtask

    task automatic runBeats(input int fromK, input int toK, input int stallPct);
        logic lbv, fw;
        bit   pendingFirst = 0;
        for (int k = fromK; k <= toK; k++) begin
            applyStimulus(k == 0, (k % W) == W - 1, stallPct, lbv, fw);
            checkOutput("lb_in_valid_beat", lbv, 1);
            if (pendingFirst) checkOutput("first_win_latency", fw, 1);
            pendingFirst = (k == W + 1);
            if (k >= W + 1) pushWindow(k - W - 1);
            if (k == W * H - 1)
                for (int j = W * H - W - 1; j < W * H; j++) pushWindow(j);
        end
    endtask

    task automatic checkFlush();
        for (int i = 0; i < W + 1; i++) begin
            s_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            checkOutput("flush_s_ready", s_ready, 0);
            checkOutput("flush_pad_sel", pad_sel, 1);
            checkOutput("flush_lb_in_valid", lb_in_valid, 1);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        @(negedge clk);
        checkOutput("post_flush_s_ready", s_ready, 1);
        checkOutput("post_flush_pad_sel", pad_sel, 0);
        @(posedge clk); #1;
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 20 && sbq.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        checkOutput("scoreboard_drained", sbq.size(), 0);
    endtask

    task automatic goodFrame(input int stallPct);
        runBeats(0, W * H - 1, stallPct);
        checkFlush();
        waitDrain();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset_n = 1'b0;
        s_valid = 1'b0;
        s_sof   = 1'b0;
        s_eol   = 1'b0;
        err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("reset_lb_reset", lb_reset, 1);
        checkOutput("reset_err_eol", err_eol, 0);
        checkOutput("reset_win_valid", win_valid, 0);
        checkOutput("reset_pad_sel", pad_sel, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("release_s_ready", s_ready, 1);
        checkOutput("release_lb_reset", lb_reset, 0);
        @(posedge clk); #1;

        $display("[TB] beats without s_sof in IDLE");
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1;
            s_sof   = 1'b0;
            s_eol   = 1'(i);
            @(negedge clk);
            checkOutput("idle_no_sof_lb_in_valid", lb_in_valid, 0);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        s_eol   = 1'b0;

        $display("[TB] continuous frame");
        goodFrame(0);

        $display("[TB] frame with random s_valid stalls");
        goodFrame(40);

        $display("[TB] s_eol at row 1 col 2");
        runBeats(0, W + 1, 0);
        s_valid = 1'b1;
        s_eol   = 1'b1;
        @(negedge clk);
        checkOutput("err_beat_discarded", lb_in_valid, 0);
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_eol   = 1'b0;
        @(negedge clk);
        checkOutput("err_eol_set", err_eol, 1);
        checkOutput("err_lb_reset", lb_reset, 1);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("err_lb_reset_pulse", lb_reset, 0);
        checkOutput("err_eol_sticky", err_eol, 1);
        @(posedge clk); #1;
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        @(negedge clk);
        checkOutput("err_eol_cleared", err_eol, 0);
        @(posedge clk); #1;
        goodFrame(0);

        $display("[TB] error with simultaneous err_clr");
        runBeats(0, 1, 0);
        s_valid = 1'b1;
        s_eol   = 1'b1;
        err_clr = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_eol   = 1'b0;
        err_clr = 1'b0;
        @(negedge clk);
        checkOutput("err_set_wins", err_eol, 1);
        @(posedge clk); #1;
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        @(negedge clk);
        checkOutput("err_eol_cleared2", err_eol, 0);
        @(posedge clk); #1;

        $display("[TB] s_sof injected at row 1 col 3");
        runBeats(0, W + 2, 0);
        runBeats(0, 0, 0);
        @(negedge clk);
        checkOutput("sof_lb_reset", lb_reset, 1);
        checkOutput("sof_no_err", err_eol, 0);
        @(posedge clk); #1;
        runBeats(1, W * H - 1, 0);
        checkFlush();
        waitDrain();

`ifdef DPC_LBCTRL_STATS_EN
        checkOutput("stats_frame_cnt_4", frame_cnt, 4);
        checkOutput("stats_err_cnt_2", err_cnt, 2);
`endif

        $display("[TB] reset during FLUSH");
        runBeats(0, W * H - 1, 0);
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        sbq.delete();
        @(negedge clk);
        checkOutput("flush_reset_lb_reset", lb_reset, 1);
        checkOutput("flush_reset_win_valid", win_valid, 0);
        checkOutput("flush_reset_pad_sel", pad_sel, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("flush_reset_s_ready", s_ready, 1);
        checkOutput("flush_reset_frame_done", frame_done, 0);
        repeat (8) @(posedge clk);
        #1;

        goodFrame(0);
        goodFrame(25);
`ifdef DPC_LBCTRL_STATS_EN
        checkOutput("stats_frame_cnt_2", frame_cnt, 2);
        checkOutput("stats_err_cnt_0", err_cnt, 0);
`endif

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
